fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one-entry buffer between the instruction bus and decode,
// with delay-slot branches, exception flush redirects and misaligned-PC detection.
`timescale 1ns/1ps
module fetch_ctrl (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_ack_i,
  input  logic [31:0] ibus_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic [4:0]  if_exc_code_o,
  output logic [31:0] if_exc_badvaddr_o,
  output logic [1:0]  fsm_state_o
);

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam logic [4:0]  EC_NONE  = 5'h00;
  localparam logic [4:0]  EC_ADEL  = 5'h04;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH     = 2'd1,
    WAIT_CONS = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc_r;
  logic [31:0] br_tgt_r;
  logic [31:0] kill_tgt_r;
  logic        br_pend_r;
  logic        kill_pend_r;
  logic [31:0] next_pc;
  logic        aligned;
  logic        consume;

  // Handshakes: the bus transfers a word on any cycle where ibus_req_o and ibus_ack_i are
  // both high (ack may be combinational); decode takes the buffer when inst_valid_o & ~stall_i.
  assign aligned     = (pc_r[1:0] == 2'b00);
  assign ibus_req_o  = (state == FETCH) && aligned;
  assign ibus_addr_o = {3'b000, pc_r[28:0]};
  assign consume     = inst_valid_o & ~stall_i;
  assign fsm_state_o = state;

  always_comb begin
    next_pc = pc_r + 32'd4;
    if (br_taken_i)
      next_pc = br_target_i;
    else if (br_pend_r)
      next_pc = br_tgt_r;
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state             <= IDLE;
      pc_r              <= RESET_PC;
      br_tgt_r          <= 32'h0;
      kill_tgt_r        <= 32'h0;
      br_pend_r         <= 1'b0;
      kill_pend_r       <= 1'b0;
      inst_valid_o      <= 1'b0;
      inst_o            <= 32'h0;
      inst_pc_o         <= 32'h0;
      if_exc_code_o     <= EC_NONE;
      if_exc_badvaddr_o <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (flush_i) begin
            pc_r      <= flush_pc_i;
            br_pend_r <= 1'b0;
          end
          state <= FETCH;
        end

        FETCH: begin
          if (!aligned) begin
            // No bus cycle: the fault itself is what decode receives.
            if (flush_i) begin
              pc_r      <= flush_pc_i;
              br_pend_r <= 1'b0;
            end else begin
              inst_valid_o      <= 1'b1;
              inst_o            <= 32'h0;
              inst_pc_o         <= pc_r;
              if_exc_code_o     <= EC_ADEL;
              if_exc_badvaddr_o <= pc_r;
              state             <= WAIT_CONS;
              if (br_taken_i) begin
                br_pend_r <= 1'b1;
                br_tgt_r  <= br_target_i;
              end
            end
          end else if (ibus_ack_i) begin
            if (flush_i) begin
              pc_r        <= flush_pc_i;
              kill_pend_r <= 1'b0;
              br_pend_r   <= 1'b0;
            end else if (kill_pend_r) begin
              pc_r        <= kill_tgt_r;
              kill_pend_r <= 1'b0;
              br_pend_r   <= 1'b0;
            end else begin
              inst_valid_o      <= 1'b1;
              inst_o            <= ibus_rdata_i;
              inst_pc_o         <= pc_r;
              if_exc_code_o     <= EC_NONE;
              if_exc_badvaddr_o <= 32'h0;
              pc_r              <= next_pc;
              br_pend_r         <= 1'b0;
              state             <= WAIT_CONS;
            end
          end else begin
            // Request outstanding: redirects are remembered until the ack retires it.
            if (flush_i) begin
              kill_pend_r <= 1'b1;
              kill_tgt_r  <= flush_pc_i;
              br_pend_r   <= 1'b0;
            end else if (br_taken_i && !kill_pend_r) begin
              br_pend_r <= 1'b1;
              br_tgt_r  <= br_target_i;
            end
          end
        end

        WAIT_CONS: begin
          if (flush_i) begin
            inst_valid_o <= 1'b0;
            pc_r         <= flush_pc_i;
            br_pend_r    <= 1'b0;
            state        <= FETCH;
          end else begin
            if (br_taken_i) begin
              pc_r      <= br_target_i;
              br_pend_r <= 1'b0;
            end else if (br_pend_r) begin
              pc_r      <= br_tgt_r;
              br_pend_r <= 1'b0;
            end
            if (consume) begin
              inst_valid_o <= 1'b0;
              state        <= FETCH;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
